// File: rtl/score_controller.sv
// Two-team saturating score controller: one pending slot per team, round-robin update path,
// and display sequencing. Define SCORE_CTRL_HOLD_EN to hold the display on a just-changed team.
module score_controller #(
  parameter int BW        = 7,
  parameter int MAX_SCORE = 99,
  parameter int SHOW_MS   = 2000,
  parameter int HOLD_MS   = 3000
) (
  input  logic          clk_1khz_i,
  input  logic          rst_i,
  input  logic          up_a_i,
  input  logic          down_a_i,
  input  logic          up_b_i,
  input  logic          down_b_i,
  input  logic          clear_i,
  output logic [BW-1:0] score_a_o,
  output logic [BW-1:0] score_b_o,
  output logic          disp_sel_o,
  output logic [BW-1:0] disp_val_o,
  output logic          drop_o
);

  typedef enum logic [1:0] {SLOT_NONE, SLOT_UP, SLOT_DOWN} slot_t;
  typedef enum logic [1:0] {SHOW_A, SHOW_B, HOLD} state_t;

  localparam int MAX_DWELL = (SHOW_MS > HOLD_MS) ? SHOW_MS : HOLD_MS;
  localparam int CW        = (MAX_DWELL > 2) ? $clog2(MAX_DWELL) : 1;

  slot_t          slot_a, slot_b;
  logic           last_b;          // last grant went to B
  state_t         state;
  logic [CW-1:0]  cnt;

  logic           grant_a, grant_b;
  logic           pulse_a, pulse_b;
  logic           drop_a, drop_b;
  slot_t          slot_a_d, slot_b_d;
  logic [BW-1:0]  next_a, next_b;

  function automatic logic [BW-1:0] apply_op(input logic [BW-1:0] s, input slot_t op);
    apply_op = s;
    if (op == SLOT_UP && s < BW'(MAX_SCORE))
      apply_op = s + 1'b1;
    else if (op == SLOT_DOWN && s != '0)
      apply_op = s - 1'b1;
  endfunction

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    grant_a  = 1'b0;
    grant_b  = 1'b0;
    pulse_a  = up_a_i ^ down_a_i;
    pulse_b  = up_b_i ^ down_b_i;
    drop_a   = 1'b0;
    drop_b   = 1'b0;
    slot_a_d = slot_a;
    slot_b_d = slot_b;

    // Under contention the team opposite the last grant wins.
    if (slot_a != SLOT_NONE && (slot_b == SLOT_NONE || last_b))
      grant_a = 1'b1;
    else if (slot_b != SLOT_NONE)
      grant_b = 1'b1;

    if (grant_a)
      slot_a_d = SLOT_NONE;
    if (grant_b)
      slot_b_d = SLOT_NONE;

    // A slot accepts a new pulse if it is empty or is draining this cycle.
    if (pulse_a) begin
      if (slot_a == SLOT_NONE || grant_a)
        slot_a_d = up_a_i ? SLOT_UP : SLOT_DOWN;
      else
        drop_a = 1'b1;
    end
    if (pulse_b) begin
      if (slot_b == SLOT_NONE || grant_b)
        slot_b_d = up_b_i ? SLOT_UP : SLOT_DOWN;
      else
        drop_b = 1'b1;
    end

    next_a = grant_a ? apply_op(score_a_o, slot_a) : score_a_o;
    next_b = grant_b ? apply_op(score_b_o, slot_b) : score_b_o;
  end

  assign disp_val_o = disp_sel_o ? score_b_o : score_a_o;

  always_ff @(posedge clk_1khz_i or posedge rst_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (rst_i) begin
      slot_a     <= SLOT_NONE;
      slot_b     <= SLOT_NONE;
      last_b     <= 1'b1;
      score_a_o  <= '0;
      score_b_o  <= '0;
      drop_o     <= 1'b0;
      state      <= SHOW_A;
      disp_sel_o <= 1'b0;
      cnt        <= '0;
    end else if (clear_i) begin
      slot_a     <= SLOT_NONE;
      slot_b     <= SLOT_NONE;
      last_b     <= 1'b1;
      score_a_o  <= '0;
      score_b_o  <= '0;
      drop_o     <= 1'b0;
      state      <= SHOW_A;
      disp_sel_o <= 1'b0;
      cnt        <= '0;
    end else begin
      slot_a    <= slot_a_d;
      slot_b    <= slot_b_d;
      score_a_o <= next_a;
      score_b_o <= next_b;
      drop_o    <= drop_o | drop_a | drop_b;
      if (grant_a || grant_b)
        last_b <= grant_b;

`ifdef SCORE_CTRL_HOLD_EN
      // A real score change pre-empts the dwell sequence in any state.
      if (grant_a && next_a != score_a_o) begin
        state      <= HOLD;
        disp_sel_o <= 1'b0;
        cnt        <= '0;
      end else if (grant_b && next_b != score_b_o) begin
        state      <= HOLD;
        disp_sel_o <= 1'b1;
        cnt        <= '0;
      end else
`endif
      begin
        case (state)
          SHOW_A: begin
            if (cnt == CW'(SHOW_MS - 1)) begin
              state      <= SHOW_B;
              disp_sel_o <= 1'b1;
              cnt        <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          SHOW_B: begin
            if (cnt == CW'(SHOW_MS - 1)) begin
              state      <= SHOW_A;
              disp_sel_o <= 1'b0;
              cnt        <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
`ifdef SCORE_CTRL_HOLD_EN
          HOLD: begin
            if (cnt == CW'(HOLD_MS - 1)) begin
              state      <= disp_sel_o ? SHOW_A : SHOW_B;
              disp_sel_o <= ~disp_sel_o;
              cnt        <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
`endif
          default: begin
            state      <= SHOW_A;
            disp_sel_o <= 1'b0;
            cnt        <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_score_controller.sv
// Directed bench for score_controller: table of scoring/arbitration vectors plus
// hand-written display, saturation and reset sequences (SHOW_MS=4, HOLD_MS=6).
module tb_score_controller;

`ifdef SCORE_CTRL_HOLD_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  localparam int BW = 7;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          up_a = 1'b0, down_a = 1'b0, up_b = 1'b0, down_b = 1'b0, clear = 1'b0;
  logic [BW-1:0] score_a, score_b, disp_val;
  logic          disp_sel, drop;

  int n_checks = 0;
  int n_pass   = 0;

  score_controller #(.BW(BW), .MAX_SCORE(99), .SHOW_MS(4), .HOLD_MS(6)) dut (
    .clk_1khz_i (clk),
    .rst_i      (rst),
    .up_a_i     (up_a),
    .down_a_i   (down_a),
    .up_b_i     (up_b),
    .down_b_i   (down_b),
    .clear_i    (clear),
    .score_a_o  (score_a),
    .score_b_o  (score_b),
    .disp_sel_o (disp_sel),
    .disp_val_o (disp_val),
    .drop_o     (drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic up_a, down_a, up_b, down_b, clear;
    int   exp_a, exp_b;
    logic exp_drop;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic ua, input logic da, input logic ub, input logic db, input logic cl);
    up_a = ua; down_a = da; up_b = ub; down_b = db; clear = cl;
  endtask

  // Leaves the bench 1 time unit after "edge 0"; the next posedge is edge 1.
  task automatic do_reset();
    set_in(0, 0, 0, 0, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Strict alternation: sel after edge k with SHOW_MS=4.
  function automatic int alt_sel(input int k);
    return (k / 4) % 2;
  endfunction

  initial begin
    int hold2[11];
    int hold3[11];

    // ---- Reset state and idle alternation ----
    do_reset();
    check("reset score_a", score_a, 0);
    check("reset score_b", score_b, 0);
    check("reset disp_val", disp_val, 0);
    check("reset drop", drop, 0);
    check("idle sel e0", disp_sel, 0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      check($sformatf("idle sel e%0d", k), disp_sel, alt_sel(k));
    end
    check("idle score_a", score_a, 0);
    check("idle drop", drop, 0);

    // ---- up_a at edge 10: update at 11, hold A for 6 cycles ----
    hold2 = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0};   // edges 11..21
    do_reset();
    repeat (9) tick();
    up_a = 1'b1;
    tick();
    up_a = 1'b0;
    check("up_a loaded not yet applied", score_a, 0);
    for (int k = 11; k <= 21; k++) begin
      int es;
      tick();
      es = HOLD_EN ? hold2[k-11] : alt_sel(k);
      check($sformatf("upA sel e%0d", k), disp_sel, es);
      check($sformatf("upA val e%0d", k), disp_val, es ? 0 : 1);
    end
    check("upA score_a", score_a, 1);

    // ---- up_b at edge 1, then up_a at edge 4 retriggers the hold ----
    hold3 = '{1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1};   // edges 2..12
    do_reset();
    up_b = 1'b1;
    tick();
    up_b = 1'b0;
    for (int k = 2; k <= 12; k++) begin
      up_a = (k == 4);
      tick();
      check($sformatf("retrig sel e%0d", k), disp_sel, HOLD_EN ? hold3[k-2] : alt_sel(k));
    end
    up_a = 1'b0;
    check("retrig score_a", score_a, 1);
    check("retrig score_b", score_b, 1);

    // ---- Table: arbitration, cancellation, drop and clear ----
    //          ua da ub db cl   A  B  drop      edge
    vecs[0]  = '{1, 0, 1, 0, 0,  0, 0, 0};  // 1  both slots loaded
    vecs[1]  = '{0, 0, 0, 0, 0,  1, 0, 0};  // 2  A wins from reset
    vecs[2]  = '{0, 0, 0, 0, 0,  1, 1, 0};  // 3  B one cycle later
    vecs[3]  = '{1, 0, 0, 0, 0,  1, 1, 0};  // 4  lone A
    vecs[4]  = '{0, 0, 0, 0, 0,  2, 1, 0};  // 5  A granted, pointer now A
    vecs[5]  = '{1, 0, 1, 0, 0,  2, 1, 0};  // 6  pair again
    vecs[6]  = '{0, 0, 0, 0, 0,  2, 2, 0};  // 7  B first this time
    vecs[7]  = '{0, 0, 0, 0, 0,  3, 2, 0};  // 8  then A
    vecs[8]  = '{1, 1, 0, 0, 0,  3, 2, 0};  // 9  up+down cancels
    vecs[9]  = '{0, 0, 0, 0, 0,  3, 2, 0};  // 10 nothing pending
    vecs[10] = '{1, 0, 1, 0, 0,  3, 2, 0};  // 11 pair, last grant was A
    vecs[11] = '{1, 0, 0, 0, 0,  3, 3, 1};  // 12 B wins, A slot full -> drop
    vecs[12] = '{0, 0, 0, 0, 0,  4, 3, 1};  // 13 first A applied once
    vecs[13] = '{0, 0, 0, 1, 0,  4, 3, 1};  // 14 down_b loaded
    vecs[14] = '{0, 0, 0, 0, 0,  4, 2, 1};  // 15 B decremented
    vecs[15] = '{1, 0, 1, 0, 1,  0, 0, 0};  // 16 clear wins over pulses
    vecs[16] = '{0, 0, 0, 0, 0,  0, 0, 0};  // 17 pulses in clear cycle lost
    vecs[17] = '{1, 0, 0, 0, 0,  0, 0, 0};  // 18 A loaded
    vecs[18] = '{0, 0, 0, 0, 1,  0, 0, 0};  // 19 clear flushes pending slot
    vecs[19] = '{0, 0, 0, 0, 0,  0, 0, 0};  // 20 nothing applied
    do_reset();
    for (int i = 0; i < 20; i++) begin
      set_in(vecs[i].up_a, vecs[i].down_a, vecs[i].up_b, vecs[i].down_b, vecs[i].clear);
      tick();
      set_in(0, 0, 0, 0, 0);
      check($sformatf("vec%0d score_a", i), score_a, vecs[i].exp_a);
      check($sformatf("vec%0d score_b", i), score_b, vecs[i].exp_b);
      check($sformatf("vec%0d drop", i), drop, vecs[i].exp_drop);
      if (vecs[i].clear) check($sformatf("vec%0d clear sel", i), disp_sel, 0);
    end

    // ---- Saturation at 99 and at 0; saturated grants leave the FSM alone ----
    do_reset();
    for (int k = 1; k <= 100; k++) begin
      up_a = 1'b1;
      tick();
    end
    up_a = 1'b0;
    check("sat reaches 99", score_a, 99);
    tick();                                         // edge 101: saturated grant
    check("sat stays 99", score_a, 99);
    repeat (4) tick();                              // edge 105
    check("sat sel e105", disp_sel, HOLD_EN ? 0 : alt_sel(105));
    tick();                                         // edge 106
    check("sat sel e106", disp_sel, HOLD_EN ? 1 : alt_sel(106));
    down_b = 1'b1;
    tick();                                         // edge 107
    down_b = 1'b0;
    tick();                                         // edge 108: saturated grant
    check("B floor 0", score_b, 0);
    tick();                                         // edge 109
    check("floor sel e109", disp_sel, HOLD_EN ? 1 : alt_sel(109));
    check("floor val e109", disp_val, 0);
    tick();                                         // edge 110
    check("floor sel e110", disp_sel, HOLD_EN ? 0 : alt_sel(110));
    check("floor val e110", disp_val, HOLD_EN ? 99 : 0);
    check("sat no drop", drop, 0);

    // ---- Asynchronous reset mid-cycle drops a pending pulse ----
    up_a = 1'b1;
    tick();
    up_a = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("async rst score_a", score_a, 0);
    check("async rst sel", disp_sel, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    tick();
    check("pending lost after rst", score_a, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/score_controller.md
# score_controller

Two-team score controller for the scoreboard. Takes up/down pulses from two pushbutton processors (team A, team B) and keeps one saturating score register per team. A single shared update path is granted to one team per cycle by round-robin arbitration. The block also sequences the one shared bin_to_decimal → dual_7_seg display path, alternating between the teams and holding on the team whose score just changed.

## Interface
- BW, 7: score register width; must satisfy 2^BW > MAX_SCORE
- MAX_SCORE, 99: saturation ceiling of each score
- SHOW_MS, 2000: cycles each team is shown while alternating (≥2)
- HOLD_MS, 3000: cycles a just-changed team is held on display (≥2)

- clk_1khz_i  in  1  1 kHz system clock
- rst_i  in  1  reset; asynchronous, active-high
- up_a_i  in  1  single-cycle increment pulse, team A
- down_a_i  in  1  single-cycle decrement pulse, team A
- up_b_i  in  1  single-cycle increment pulse, team B
- down_b_i  in  1  single-cycle decrement pulse, team B
- clear_i  in  1  synchronous clear of both scores
- score_a_o  out  BW  team A score (registered)
- score_b_o  out  BW  team B score (registered)
- disp_sel_o  out  1  displayed team: 0 = A, 1 = B (registered; also drives the team LED)
- disp_val_o  out  BW  displayed score = disp_sel_o ? score_b_o : score_a_o; feeds bin_to_decimal.bin_i
- drop_o  out  1  sticky: a pulse was lost because that team's pending slot was full; cleared by reset or clear_i

## Operation
- Reset: score_a_o = score_b_o = 0, disp_sel_o = 0, disp_val_o = 0, drop_o = 0, pending slots empty, round-robin pointer favours A, FSM = SHOW_A, dwell counter = 0.
- Pending slot per team, holding NONE, UP or DOWN. A pulse loads the slot if it is empty or being granted this cycle. up and down for the same team in the same cycle cancel: no load, no drop. If the slot is full and not granted, the pulse is discarded and drop_o is set.
- Arbiter: each cycle grants at most one non-empty slot. If only one slot is non-empty, that team is granted. If both are non-empty, the team opposite the last grant wins; the pointer updates on every grant.
- Update for the granted team:
  - UP: s = s+1 if s < MAX_SCORE, else unchanged.
  - DOWN: s = s−1 if s > 0, else unchanged.
  - No wrap-around in either direction.
  - "Changed" = the value actually differs.
- FSM states: SHOW_A, SHOW_B, HOLD.
  - SHOW_A / SHOW_B: disp_sel_o = 0 / 1. The dwell counter counts 0..SHOW_MS−1; at SHOW_MS−1 it moves to the other SHOW state with counter 0.
  - Changed update of team X (any state) → HOLD, disp_sel_o = X, counter 0. A further change retriggers this: counter back to 0, sel becomes the new team.
  - HOLD at count HOLD_MS−1 → SHOW of the team opposite the held one, counter 0.
  - Saturated (unchanged) grants do not affect the FSM.
- clear_i has priority over all other activity in that cycle. It applies the reset values to every output and all state, and pulses arriving in the same cycle are discarded.
- Asynchronous reset mid-operation: all state returns to reset values immediately; pending pulses are lost.

## Timing
- Pulse sampled at edge N → slot loaded at N. Grant and score update at edge N+1; the new score is visible after N+1.
- Simultaneous A and B pulses: winner updates at N+1, loser at N+2.
- disp_sel_o changes at the same edge as the triggering score update. disp_val_o is combinational from registers (0 additional latency).
- Sustained throughput: one update per cycle, alternating teams under contention.
- Each SHOW state lasts exactly SHOW_MS cycles. An untriggered HOLD lasts exactly HOLD_MS cycles.

## Configuration
- SCORE_CTRL_HOLD_EN defined: HOLD state present as described.
- Not defined: HOLD state and HOLD_MS are unused. Score changes never affect disp_sel_o, and the display strictly alternates A/B every SHOW_MS cycles. Scoring and arbitration are unchanged.

## Test plan
(Parameters for all scenarios: SHOW_MS=4, HOLD_MS=6, MAX_SCORE=99.)
- Reset, no input → disp_sel_o sequence 0,0,0,0,1,1,1,1,0…; scores stay 0; drop_o = 0.
- up_a_i pulse at edge 10 → score_a_o = 1 after edge 11, disp_sel_o = 0 from edge 11 for 6 cycles, then 1 (SHOW_B).
- up_a_i and up_b_i at the same edge from reset → A = 1 at N+1, B = 1 at N+2. Repeating the pair → B updates first this time.
- score_a = 99 plus up_a_i → stays 99, FSM undisturbed. score_b = 0 plus down_b_i → stays 0. up_a_i and down_a_i together → no change, drop_o = 0.
- Pulses on A at consecutive edges while B keeps winning contention (slot full) → second A pulse lost, drop_o = 1; clear_i → both scores 0, drop_o = 0, disp_sel_o = 0.
- Build without SCORE_CTRL_HOLD_EN, up_b_i during SHOW_A → score_b = 1, disp_sel_o still follows the strict 4-cycle alternation.
